// File: rtl/writeback_arbiter.sv
// Register-file write port master: merges single-cycle ALU results with FIFO-buffered
// load results and tracks outstanding loads per destination for decode stalls.
module writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int AMOUNT     = 16,
    parameter int ADDRESSLEN = 4,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDRESSLEN-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDRESSLEN-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    input  logic                  iss_valid,
    input  logic [ADDRESSLEN-1:0] iss_rd,
    output logic [AMOUNT-1:0]     pend,
    output logic [XLEN-1:0]       data,
    output logic [ADDRESSLEN-1:0] rd,
    output logic                  wEn
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESSLEN-1:0] f_rd   [DEPTH];
    logic [XLEN-1:0]       f_data [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    logic                  full, push, pop, wr_sel;
    logic [ADDRESSLEN-1:0] wr_rd;
    logic [XLEN-1:0]       wr_data;
    logic [AMOUNT-1:0]     pend_nxt;

    assign full      = (count == CW'(DEPTH));
    assign ld_ready  = !full;
    assign alu_ready = !full;
    assign push      = ld_valid && !full;
    // A full FIFO takes priority so buffered loads always drain; otherwise ALU first.
    assign pop       = full || (!alu_valid && count != '0);

    always_comb begin
        wr_sel  = 1'b0;
        wr_rd   = '0;
        wr_data = '0;
        if (pop) begin
            wr_sel  = 1'b1;
            wr_rd   = f_rd[rd_ptr];
            wr_data = f_data[rd_ptr];
        end else if (alu_valid) begin
            wr_sel  = 1'b1;
            wr_rd   = alu_rd;
            wr_data = alu_data;
        end
    end

    // Clear before set so a re-issued load to the same register stays outstanding.
    always_comb begin
        pend_nxt = pend;
        if (pop)
            pend_nxt[f_rd[rd_ptr]] = 1'b0;
        if (iss_valid && iss_rd != '0)
            pend_nxt[iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_rd[wr_ptr]   <= ld_rd;
            f_data[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= '0;
            wEn    <= 1'b0;
            rd     <= '0;
            data   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            pend <= pend_nxt;
            // x0 writes are consumed but never reach the register file.
            wEn  <= wr_sel && (wr_rd != '0);
            if (wr_sel) begin
                rd   <= wr_rd;
                data <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, iss_valid = 1'b0;
    logic [3:0]  alu_rd = '0, ld_rd = '0, iss_rd = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic        alu_ready, ld_ready, wEn;
    logic [15:0] pend;
    logic [31:0] data;
    logic [3:0]  rd;

    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    writeback_arbiter #(.XLEN(32), .AMOUNT(16), .ADDRESSLEN(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .pend(pend), .data(data), .rd(rd), .wEn(wEn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffered loads as a queue, writes decided from the priority rules.
    typedef struct { logic [3:0] r; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic [15:0] m_pend = '0;
    logic        m_wen = 1'b0;
    logic [3:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    bit          m_known = 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_pend = '0; m_wen = 1'b0; m_rd = '0; m_data = '0; m_known = 1'b1;
        end else begin
            bit   full;
            ent_t e;
            bit   sel;
            full = (q.size() == DEPTH);
            sel  = 1'b0;
            if (full || (!alu_valid && q.size() != 0)) begin
                e = q.pop_front();
                m_pend[e.r] = 1'b0;
                sel = 1'b1;
            end else if (alu_valid) begin
                e.r = alu_rd; e.d = alu_data;
                sel = 1'b1;
            end
            if (sel) begin
                m_wen = (e.r != 0); m_rd = e.r; m_data = e.d; m_known = (e.r != 0);
            end else begin
                m_wen = 1'b0;
            end
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            m_pend[0] = 1'b0;
            if (ld_valid && !full) begin
                e.r = ld_rd; e.d = ld_data;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wEn", wEn, m_wen);
            chk("pend", pend, m_pend);
            chk("alu_ready", alu_ready, q.size() != DEPTH);
            chk("ld_ready", ld_ready, q.size() != DEPTH);
            if (m_known) begin
                chk("rd", rd, m_rd);
                chk("data", data, m_data);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1 wEn", wEn, 0); chk("t1 rd", rd, 0); chk("t1 data", data, 0);
        chk("t1 pend", pend, 0); chk("t1 ld_ready", ld_ready, 1); chk("t1 alu_ready", alu_ready, 1);

        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2 wEn", wEn, 1); chk("t2 rd", rd, 5); chk("t2 data", data, 32'hDEADBEEF);
        chk("t2 model data", m_data, 32'hDEADBEEF);
        alu_rd = 0;
        @(negedge clk);
        chk("t2 x0 wEn", wEn, 0);
        alu_valid = 0;

        iss_valid = 1; iss_rd = 7;
        @(negedge clk);
        iss_valid = 0;
        chk("t3 pend7 set", pend[7], 1);
        ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
        @(negedge clk);
        ld_valid = 0;
        chk("t3 pend7 held", pend[7], 1); chk("t3 no bypass", wEn, 0);
        @(negedge clk);
        chk("t3 wEn", wEn, 1); chk("t3 rd", rd, 7); chk("t3 data", data, 32'h1234);
        chk("t3 pend7 clr", pend[7], 0); chk("t3 model pend", m_pend, 16'h0000);

        iss_valid = 1; iss_rd = 3;
        @(negedge clk);
        iss_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'hAAAA0001;
        ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
        @(negedge clk);
        ld_rd = 4; ld_data = 32'h44;
        chk("t4 alu1 rd", rd, 9); chk("t4 alu_ready1", alu_ready, 1);
        @(negedge clk);
        ld_valid = 0;
        chk("t4 alu2 rd", rd, 9); chk("t4 full alu_ready", alu_ready, 0);
        chk("t4 full ld_ready", ld_ready, 0);
        iss_valid = 1; iss_rd = 3;
        @(negedge clk);
        iss_valid = 0;
        chk("t4 pop1 rd", rd, 3); chk("t4 pop1 data", data, 32'h33);
        chk("t5 pend3 kept", pend[3], 1); chk("t4 alu_ready back", alu_ready, 1);
        @(negedge clk);
        alu_valid = 0;
        chk("t4 alu3 rd", rd, 9);
        @(negedge clk);
        chk("t4 pop2 rd", rd, 4); chk("t4 pop2 data", data, 32'h44);

        iss_valid = 1; iss_rd = 7; alu_valid = 1; alu_rd = 9;
        ld_valid = 1; ld_rd = 3; ld_data = 32'h5;
        @(negedge clk);
        iss_valid = 0; ld_rd = 7; ld_data = 32'h6;
        @(negedge clk);
        ld_valid = 0;
        chk("t6 pre pend", pend, 16'h0088); chk("t6 pre full", alu_ready, 0);
        reset = 1;
        @(negedge clk);
        reset = 0; alu_valid = 0;
        chk("t6 pend", pend, 0); chk("t6 wEn", wEn, 0); chk("t6 ready", ld_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("t6 dropped", wEn, 0);
        end

        for (int i = 0; i < 600; i++) begin
            alu_valid = ($urandom_range(0, 99) < 45);
            alu_rd    = 4'($urandom_range(0, 15));
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 99) < 50);
            ld_rd     = 4'($urandom_range(0, 15));
            ld_data   = $urandom;
            iss_valid = ($urandom_range(0, 99) < 40);
            iss_rd    = 4'($urandom_range(0, 15));
            reset     = ($urandom_range(0, 99) < 2);
            @(negedge clk);
        end
        reset = 0; alu_valid = 0; ld_valid = 0; iss_valid = 0;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
